// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: FSM states, decoded request op, default widths.
// Latency/backpressure: none (types and constants only).
package mem_resp_pkg;
    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} mem_resp_state_t;
    typedef enum logic [1:0] {OP_RD = 2'd0, OP_WR = 2'd1, OP_BAD = 2'd2} mem_resp_op_t;

    function automatic mem_resp_op_t decode_op(input logic rd, input logic wr);
        if (rd && wr)
            return OP_BAD;
        else if (wr)
            return OP_WR;
        else
            return OP_RD;
    endfunction
endpackage

// File: rtl/mem_responder_if.sv
// Processor memory port: level request held by the master until a one-cycle mem_ready pulse.
// Latency/backpressure: set by the responder's wait states; the master stalls by holding its request.
interface mem_responder_if
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              mem_ready;
    logic              mem_err;
    logic              busy;

    modport master (
        output mem_read, mem_write, address, write_data,
        input  read_data, mem_ready, mem_err, busy
    );

    modport slave (
        input  mem_read, mem_write, address, write_data,
        output read_data, mem_ready, mem_err, busy
    );
endinterface

// File: rtl/mem_responder_wait_counter.sv
// 4-bit wait-state counter: synchronous load and decrement, done while the count equals 1.
// Latency: one cycle from load/decrement to the new count; no backpressure.
module wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       done_o
);
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && (cnt_q != 4'd0))
            cnt_d = cnt_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == 4'd1);
endmodule

// File: rtl/mem_responder.sv
// Byte-array memory responder; mem_ready pulses WAIT_STATES+1 cycles after acceptance, master holds request meanwhile.
// MEM_RESP_WRITE_PROTECT_EN drops writes below PROTECT_LIMIT and flags them on mem_err.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int                ADDR_W        = ADDR_W_DEF,
    parameter int                DATA_W        = DATA_W_DEF,
    parameter int                WAIT_STATES   = 2,
    parameter logic [ADDR_W-1:0] PROTECT_LIMIT = ADDR_W'('h0400)
) (
    input  logic             clk,
    input  logic             rst,
    mem_responder_if.slave   bus
);
`ifdef MEM_RESP_WRITE_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    mem_resp_state_t   state_q, state_d;
    mem_resp_op_t      op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic [DATA_W-1:0] rdat_q, rdat_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    logic cnt_load, cnt_dec, cnt_done;
    logic req, accept, wr_blocked, wr_commit;

    wait_counter u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (WS_LOAD),
        .dec_i      (cnt_dec),
        .done_o     (cnt_done)
    );

    // The IDLE cycle that carries mem_ready is not an acceptance slot: a request
    // is a repeat only if it is still present in the cycle after the pulse.
    assign req        = bus.mem_read | bus.mem_write;
    assign accept     = (state_q == IDLE) && req && !ready_q;
    assign wr_blocked = PROT_EN && (addr_q < PROTECT_LIMIT);
    assign wr_commit  = (state_q == RESP) && (op_q == OP_WR) && !wr_blocked;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        rdat_d   = rdat_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d     = decode_op(bus.mem_read, bus.mem_write);
                    addr_d   = bus.address;
                    wdat_d   = bus.write_data;
                    cnt_load = 1'b1;
                    state_d  = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_done)
                    state_d = RESP;
                else
                    cnt_dec = 1'b1;
            end
            RESP: begin
                if (op_q == OP_RD)
                    rdat_d = mem_q[addr_q];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_q == RESP);
        err_d   = (state_q == RESP) && ((op_q == OP_BAD) || ((op_q == OP_WR) && wr_blocked));
        busy_d  = (state_d != IDLE) || (state_q == RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Contents survive reset; a reset landing on the RESP edge cancels the commit.
    always_ff @(posedge clk) begin
        if (rst && wr_commit)
            mem_q[addr_q] <= wdat_q;
    end

    assign bus.read_data = rdat_q;
    assign bus.mem_ready = ready_q;
    assign bus.mem_err   = err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder; two instances (0 and 2 wait states) against a flat memory model.
module tb_mem_responder;
    localparam int                AW   = 13;
    localparam int                DW   = 8;
    localparam logic [AW-1:0]     PLIM = 13'h0400;
`ifdef MEM_RESP_WRITE_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          rd_r   [2];
    logic          wr_r   [2];
    logic [AW-1:0] addr_r [2];
    logic [DW-1:0] wdat_r [2];
    logic [DW-1:0] rdat_s [2];
    logic          rdy_s  [2];
    logic          err_s  [2];
    logic          busy_s [2];

    mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus_ws0 ();
    mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus_ws2 ();

    assign bus_ws0.mem_read   = rd_r[0];
    assign bus_ws0.mem_write  = wr_r[0];
    assign bus_ws0.address    = addr_r[0];
    assign bus_ws0.write_data = wdat_r[0];
    assign rdat_s[0]          = bus_ws0.read_data;
    assign rdy_s[0]           = bus_ws0.mem_ready;
    assign err_s[0]           = bus_ws0.mem_err;
    assign busy_s[0]          = bus_ws0.busy;

    assign bus_ws2.mem_read   = rd_r[1];
    assign bus_ws2.mem_write  = wr_r[1];
    assign bus_ws2.address    = addr_r[1];
    assign bus_ws2.write_data = wdat_r[1];
    assign rdat_s[1]          = bus_ws2.read_data;
    assign rdy_s[1]           = bus_ws2.mem_ready;
    assign err_s[1]           = bus_ws2.mem_err;
    assign busy_s[1]          = bus_ws2.busy;

    mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0), .PROTECT_LIMIT(PLIM)) u_dut_ws0 (
        .clk (clk),
        .rst (rst),
        .bus (bus_ws0.slave)
    );

    mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(2), .PROTECT_LIMIT(PLIM)) u_dut_ws2 (
        .clk (clk),
        .rst (rst),
        .bus (bus_ws2.slave)
    );

    // Reference: flat byte array per instance plus the last value a completed read returned.
    logic [DW-1:0] model_mem [2][2**AW];
    bit            known     [2][2**AW];
    logic [DW-1:0] model_rd  [2];
    bit            rd_known  [2];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // d=0 -> zero wait states, d=1 -> two wait states. hold keeps the request up past mem_ready.
    task automatic do_txn(input int d, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd, input bit hold);
        int lat      = (d == 1) ? 2 : 0;
        bit illegal  = r && w;
        bit blocked  = w && !r && PROT && (a < PLIM);
        bit exp_err  = illegal || blocked;
        @(negedge clk);
        chk("idle_busy", busy_s[d], 0);
        rd_r[d]   = r;
        wr_r[d]   = w;
        addr_r[d] = a;
        wdat_r[d] = wd;
        @(posedge clk);
        for (int k = 0; k <= lat; k++) begin
            #1;
            chk("wait_busy", busy_s[d], 1);
            chk("wait_no_ready", rdy_s[d], 0);
            @(posedge clk);
        end
        #1;
        if (r && !w) begin
            model_rd[d] = model_mem[d][a];
            rd_known[d] = known[d][a];
        end else if (w && !r && !blocked) begin
            model_mem[d][a] = wd;
            known[d][a]     = 1'b1;
        end
        chk("ready", rdy_s[d], 1);
        chk("ready_busy", busy_s[d], 1);
        chk("err", err_s[d], exp_err);
        if (rd_known[d])
            chk("read_data", rdat_s[d], model_rd[d]);
        if (!hold) begin
            rd_r[d] = 1'b0;
            wr_r[d] = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("ready_pulse", rdy_s[d], 0);
        chk("busy_after", busy_s[d], 0);
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        int            x;
        for (int d = 0; d < 2; d++) begin
            rd_r[d]     = 1'b0;
            wr_r[d]     = 1'b0;
            addr_r[d]   = '0;
            wdat_r[d]   = '0;
            model_rd[d] = '0;
            rd_known[d] = 1'b1;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", rdy_s[d], 0);
            chk("rst_err", err_s[d], 0);
            chk("rst_busy", busy_s[d], 0);
            chk("rst_rdata", rdat_s[d], 0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Write then read with two wait states
        do_txn(1, 1'b0, 1'b1, 13'h0500, 8'hA5, 1'b0);
        do_txn(1, 1'b1, 1'b0, 13'h0500, 8'h00, 1'b0);
        chk("wr_rd_a5", rdat_s[1], 8'hA5);

        // Zero wait states, top address
        do_txn(0, 1'b0, 1'b1, 13'h1FFF, 8'h3C, 1'b0);
        do_txn(0, 1'b1, 1'b0, 13'h1FFF, 8'h00, 1'b0);
        chk("ws0_rd_3c", rdat_s[0], 8'h3C);

        // Illegal request leaves the array alone
        do_txn(1, 1'b0, 1'b1, 13'h0600, 8'h11, 1'b0);
        do_txn(1, 1'b1, 1'b1, 13'h0600, 8'hFF, 1'b0);
        do_txn(1, 1'b1, 1'b0, 13'h0600, 8'h00, 1'b0);
        chk("illegal_keep", rdat_s[1], 8'h11);

        // Reset during WAIT aborts a pending write
        do_txn(1, 1'b0, 1'b1, 13'h0700, 8'h5A, 1'b0);
        @(negedge clk);
        wr_r[1]   = 1'b1;
        addr_r[1] = 13'h0700;
        wdat_r[1] = 8'h77;
        @(posedge clk);
        #1;
        chk("abort_busy_pre", busy_s[1], 1);
        @(negedge clk);
        rst     = 1'b0;
        wr_r[1] = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("abort_busy", busy_s[d], 0);
            chk("abort_rdata", rdat_s[d], 0);
            model_rd[d] = '0;
            rd_known[d] = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("abort_no_ready", rdy_s[1], 0);
        end
        do_txn(1, 1'b1, 1'b0, 13'h0700, 8'h00, 1'b0);
        chk("abort_prior", rdat_s[1], 8'h5A);

        // Request held across mem_ready is served again
        do_txn(1, 1'b1, 1'b0, 13'h0500, 8'h00, 1'b1);
        do_txn(1, 1'b1, 1'b0, 13'h0500, 8'h00, 1'b0);
        chk("b2b_rd", rdat_s[1], 8'hA5);
        do_txn(0, 1'b0, 1'b1, 13'h0420, 8'h6E, 1'b1);
        do_txn(0, 1'b1, 1'b0, 13'h0420, 8'h00, 1'b0);

        // Write into the protectable region
        do_txn(1, 1'b0, 1'b1, 13'h0010, 8'h99, 1'b0);
        do_txn(1, 1'b1, 1'b0, 13'h0010, 8'h00, 1'b0);

        // Random traffic around the protect boundary and the top of memory
        for (int n = 0; n < 300; n++) begin
            x = $urandom_range(0, 3);
            if (x == 0)
                a = AW'($urandom_range(0, 2**AW - 1));
            else if (x == 1)
                a = AW'(13'h03F8 + $urandom_range(0, 15));
            else
                a = AW'(13'h1FF0 + $urandom_range(0, 15));
            wd = DW'($urandom_range(0, 255));
            x  = $urandom_range(0, 9);
            do_txn(n % 2, (x < 5) || (x == 9), (x >= 5), a, wd, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the processor memory port: accepts read/write requests (13-bit address, 8-bit data) and completes each after a configurable number of wait states.
- Holds a 2^ADDR_W x DATA_W byte array that provides both program and data storage.
- The datapath controller holds its request until it sees a one-cycle `mem_ready` pulse. This allows multi-cycle memory without changing the datapath.

Parameters:
- ADDR_W, 13, address width; depth = 2**ADDR_W
- DATA_W, 8, data word width
- WAIT_STATES, 2, cycles between request acceptance and `mem_ready`; legal range 0..15
- PROTECT_LIMIT, 13'h0400, first writable address (used only with the optional feature)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on the clk rising edge)
- mem_read  in  1  read request, level, held until `mem_ready`
- mem_write  in  1  write request, level, held until `mem_ready`
- address  in  ADDR_W  request address, stable while the request is held
- write_data  in  DATA_W  write data, stable while the request is held
- read_data  out  DATA_W  read result, valid in the `mem_ready` cycle and held until the next read completes
- mem_ready  out  1  one-cycle completion pulse
- mem_err  out  1  one-cycle pulse coincident with `mem_ready` on an illegal request
- busy  out  1  high from request acceptance until the `mem_ready` cycle inclusive

Behaviour:
- Reset (rst == 0 at a clk edge):
  - FSM goes to IDLE; wait counter cleared.
  - `read_data` = 0, `mem_ready` = 0, `mem_err` = 0, `busy` = 0.
  - Array contents are NOT cleared.
  - Reset mid-transaction aborts it: no `mem_ready`, and a pending write is not committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On (`mem_read` | `mem_write`): latch address, write_data and op into internal registers; load counter = WAIT_STATES.
  - If WAIT_STATES == 0 go to RESP, else go to WAIT.
  - `busy` rises in the cycle after acceptance (registered).
- WAIT:
  - Counter decrements each cycle; go to RESP when the counter reaches 1.
  - Request inputs are ignored; only the latched values are used.
- RESP (one cycle):
  - Read: `read_data` <= array[latched address].
  - Write: array[latched address] <= latched data; `read_data` unchanged.
  - `mem_ready` = 1 for this cycle; next state IDLE.
- Latency: `mem_ready` is asserted WAIT_STATES+1 cycles after the acceptance edge.
- Back-to-back requests: a request still asserted in the cycle after `mem_ready` is treated as a new request and accepted from IDLE. The initiator therefore drops its request in the `mem_ready` cycle unless it intends a repeat.
- Illegal request (`mem_read` & `mem_write` both 1 at acceptance):
  - Follows the normal timing, with no array write and `read_data` unchanged.
  - `mem_err` = 1 together with `mem_ready`.
- Addresses cover the full 2^ADDR_W range; there is no out-of-range condition.
- Outputs are registered. Array reads are synchronous in RESP.

Optional Feature:
- Macro: MEM_RESP_WRITE_PROTECT_EN.
- Defined: a write with latched address < PROTECT_LIMIT is dropped (array unchanged) and `mem_err` pulses with `mem_ready`. Reads are unaffected.
- Undefined: all addresses are writable; `mem_err` is driven only by the illegal-request case.

Decomposition:
- Package `mem_resp_pkg` holds:
  - the state enum `mem_resp_state_t` {IDLE, WAIT, RESP};
  - the op enum {OP_RD, OP_WR, OP_BAD};
  - default constants ADDR_W_DEF = 13 and DATA_W_DEF = 8.
- One sub-module: `wait_counter` (4-bit, synchronous load/decrement, `done` flag at count == 1).

Test Plan:
- Write then read, WAIT_STATES=2:
  - `mem_write` addr 13'h0500, data 8'hA5 → `mem_ready` 3 cycles after acceptance, `busy` high throughout.
  - Then `mem_read` addr 13'h0500 → `read_data` = 8'hA5 at `mem_ready`, `mem_err` = 0.
- WAIT_STATES=0, read addr 13'h1FFF (previously written 8'h3C) → `mem_ready` 1 cycle after acceptance, `read_data` = 8'h3C.
- `mem_read` and `mem_write` both high at addr 13'h0600 (holds 8'h11), write_data 8'hFF:
  - `mem_ready` and `mem_err` pulse together.
  - A subsequent read of 13'h0600 returns 8'h11.
- Reset mid-transaction: `mem_write` addr 13'h0700, data 8'h77; rst = 0 during WAIT:
  - No `mem_ready`; outputs return to 0.
  - A later read of 13'h0700 returns the prior value.
- Request held across `mem_ready` → a second transaction is accepted from IDLE and a second `mem_ready` follows WAIT_STATES+1 cycles later.
- With MEM_RESP_WRITE_PROTECT_EN, write 8'h99 to 13'h0010 → `mem_err` pulses and a read of 13'h0010 is unchanged.
- Without the macro, the same write succeeds.
